// File: rtl/mem_initiator.sv
// Request/response initiator for a simple synchronous memory. Writes take one
// single-beat access. Reads are bursts of req_len+1 beats, each READ_WAIT cycles long.
module mem_initiator #(
  parameter int READ_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [3:0] req_len,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_last,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out,
  output logic       mem_read_write,
  output logic       mem_chip_en,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Once raised, rsp_valid and its payload hold until rsp_ready.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

  state_e     state_q, state_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] beats_q, beats_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      beats_q <= 4'd0;
      wait_q  <= 4'd0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // Writes are always single-beat regardless of req_len.
          beats_d = req_write ? 4'd0 : req_len;
          wait_d  = req_write ? 4'd0 : WAIT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (write_q || wait_q == 4'd0) begin
          rdata_d = write_q ? 8'h00 : mem_data_out;
          state_d = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (beats_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 8'd1;
            beats_d = beats_q - 4'd1;
            wait_d  = WAIT_INIT;
            state_d = ACCESS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and write data come straight from registers, so they hold outside ACCESS.
  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign mem_chip_en    = (state_q == ACCESS);
  assign mem_read_write = (state_q == ACCESS) && write_q;
  assign mem_address    = addr_q;
  assign mem_data_in    = wdata_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_last       = (state_q == RESP) && (beats_q == 4'd0);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with READ_WAIT=2 and a combinational memory
// model that returns either ~address or a fixed 0xA5.
module tb_mem_initiator;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [3:0] req_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_last;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       mem_read_write;
  logic       mem_chip_en;
  logic       busy;
  logic [1:0] dbg_state;

  logic       mem_mode;  // 1: constant 0xA5, 0: ~address
  int         errors;
  int         checks;

  mem_initiator #(.READ_WAIT(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_len       (req_len),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_last      (rsp_last),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_read_write(mem_read_write),
    .mem_chip_en   (mem_chip_en),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  always_comb mem_data_out = mem_mode ? 8'hA5 : ~mem_address;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present a request for one cycle (edge T accepts it).
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [3:0] len);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_len   = len;
    check("issue_ready", 8'(req_ready), 8'h01);
    tick();
    req_valid = 1'b0;
  endtask

  // Full write transaction with rsp_ready high; returns in IDLE.
  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d, input logic [3:0] len);
    rsp_ready = 1'b1;
    issue(1'b1, a, d, len);
    check({tag, "_acc_ce"}, 8'(mem_chip_en), 8'h01);
    check({tag, "_acc_rw"}, 8'(mem_read_write), 8'h01);
    check({tag, "_acc_addr"}, mem_address, a);
    check({tag, "_acc_din"}, mem_data_in, d);
    check({tag, "_acc_rspv"}, 8'(rsp_valid), 8'h00);
    tick();
    check({tag, "_rsp_v"}, 8'(rsp_valid), 8'h01);
    check({tag, "_rsp_last"}, 8'(rsp_last), 8'h01);
    check({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    check({tag, "_rsp_ce"}, 8'(mem_chip_en), 8'h00);
    tick();
    check({tag, "_idle_v"}, 8'(rsp_valid), 8'h00);
    check({tag, "_idle_ready"}, 8'(req_ready), 8'h01);
    check({tag, "_idle_addr_hold"}, mem_address, a);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    mem_mode  = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    req_len   = 4'd0;
    rsp_ready = 1'b0;
    #12;

    // Reset state
    check("rst_req_ready", 8'(req_ready), 8'h01);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_rsp_valid", 8'(rsp_valid), 8'h00);
    check("rst_rsp_last", 8'(rsp_last), 8'h00);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_ce", 8'(mem_chip_en), 8'h00);
    check("rst_addr", mem_address, 8'h00);
    check("rst_din", mem_data_in, 8'h00);
    check("rst_state", 8'(dbg_state), 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Single write, response at T+2
    do_write("wr1", 8'h10, 8'hA5, 4'd0);

    // Read with READ_WAIT=2, constant memory data
    mem_mode = 1'b1;
    issue(1'b0, 8'h10, 8'h00, 4'd0);
    check("rd1_c1_ce", 8'(mem_chip_en), 8'h01);
    check("rd1_c1_rw", 8'(mem_read_write), 8'h00);
    check("rd1_c1_addr", mem_address, 8'h10);
    tick();
    check("rd1_c2_ce", 8'(mem_chip_en), 8'h01);
    check("rd1_c2_rspv", 8'(rsp_valid), 8'h00);
    tick();
    check("rd1_rsp_v", 8'(rsp_valid), 8'h01);
    check("rd1_rsp_rdata", rsp_rdata, 8'hA5);
    check("rd1_rsp_last", 8'(rsp_last), 8'h01);
    check("rd1_rsp_ce", 8'(mem_chip_en), 8'h00);
    tick();
    check("rd1_idle_v", 8'(rsp_valid), 8'h00);

    // 4-beat read wrapping past 0xFF
    mem_mode = 1'b0;
    issue(1'b0, 8'hFE, 8'h00, 4'd3);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] ea;
      ea = 8'hFE + 8'(b);
      check($sformatf("burst_b%0d_ce", b), 8'(mem_chip_en), 8'h01);
      check($sformatf("burst_b%0d_addr", b), mem_address, ea);
      tick();
      tick();
      check($sformatf("burst_b%0d_v", b), 8'(rsp_valid), 8'h01);
      check($sformatf("burst_b%0d_rdata", b), rsp_rdata, ~ea);
      check($sformatf("burst_b%0d_last", b), 8'(rsp_last), (b == 3) ? 8'h01 : 8'h00);
      tick();
    end
    check("burst_idle_v", 8'(rsp_valid), 8'h00);
    check("burst_idle_ready", 8'(req_ready), 8'h01);

    // Response stall on beat 1 of a 2-beat read
    rsp_ready = 1'b0;
    issue(1'b0, 8'h20, 8'h00, 4'd1);
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall%0d_v", s), 8'(rsp_valid), 8'h01);
      check($sformatf("stall%0d_rdata", s), rsp_rdata, 8'hDF);
      check($sformatf("stall%0d_last", s), 8'(rsp_last), 8'h00);
      check($sformatf("stall%0d_ce", s), 8'(mem_chip_en), 8'h00);
      if (s < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_b2_ce", 8'(mem_chip_en), 8'h01);
    check("stall_b2_addr", mem_address, 8'h21);
    check("stall_b2_v", 8'(rsp_valid), 8'h00);
    tick();
    tick();
    check("stall_b2_rdata", rsp_rdata, 8'hDE);
    check("stall_b2_last", 8'(rsp_last), 8'h01);
    tick();
    check("stall_idle", 8'(dbg_state), 8'h00);

    // Reset during beat 2 access of a 4-beat read
    issue(1'b0, 8'h40, 8'h00, 4'd3);
    tick();
    tick();
    tick();
    check("mid_b2_ce", 8'(mem_chip_en), 8'h01);
    check("mid_b2_addr", mem_address, 8'h41);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce", 8'(mem_chip_en), 8'h00);
    check("mid_rst_v", 8'(rsp_valid), 8'h00);
    check("mid_rst_ready", 8'(req_ready), 8'h01);
    check("mid_rst_busy", 8'(busy), 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_v", 8'(rsp_valid), 8'h00);
    do_write("wr2", 8'h55, 8'h3C, 4'd0);

    // Back-to-back writes with req_valid held high; second has nonzero len
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h30;
    req_wdata = 8'h11;
    req_len   = 4'd0;
    tick();
    check("b2b_acc_ready", 8'(req_ready), 8'h00);
    check("b2b_acc_busy", 8'(busy), 8'h01);
    req_addr  = 8'h31;
    req_wdata = 8'h22;
    req_len   = 4'd5;
    tick();
    check("b2b_rsp_ready", 8'(req_ready), 8'h00);
    check("b2b_rsp_v", 8'(rsp_valid), 8'h01);
    tick();
    check("b2b_stall_ready", 8'(req_ready), 8'h00);
    check("b2b_stall_addr", mem_address, 8'h30);
    rsp_ready = 1'b1;
    tick();
    check("b2b_idle_ready", 8'(req_ready), 8'h01);
    check("b2b_idle_v", 8'(rsp_valid), 8'h00);
    tick();
    req_valid = 1'b0;
    check("b2b_w2_ce", 8'(mem_chip_en), 8'h01);
    check("b2b_w2_addr", mem_address, 8'h31);
    check("b2b_w2_din", mem_data_in, 8'h22);
    tick();
    check("b2b_w2_last", 8'(rsp_last), 8'h01);
    check("b2b_w2_rdata", rsp_rdata, 8'h00);
    tick();
    check("b2b_w2_idle", 8'(dbg_state), 8'h00);
    check("b2b_w2_v", 8'(rsp_valid), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter READ_WAIT, default 1, meaning memory read-access cycles per beat before data_out is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  request accepted when high with req_valid.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  start address.
REQ-008 req_wdata  input  8  write data.
REQ-009 req_len  input  4  read burst beats minus 1; ignored for writes.
REQ-010 rsp_valid  output  1  response beat available.
REQ-011 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-012 rsp_rdata  output  8  read data; 0 for write acknowledge.
REQ-013 rsp_last  output  1  final beat of the request.
REQ-014 mem_address  output  8  address to memory.
REQ-015 mem_data_in  output  8  write data to memory.
REQ-016 mem_data_out  input  8  read data from memory.
REQ-017 mem_read_write  output  1  1 = write, 0 = read, toward memory.
REQ-018 mem_chip_en  output  1  memory enable.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-021 req_ready SHALL be high exactly when the FSM is in IDLE.
REQ-022 On acceptance at edge T, the block SHALL register req_write, req_addr, req_wdata and req_len, then enter ACCESS.
REQ-023 In ACCESS, mem_chip_en SHALL be 1, mem_address SHALL equal the current beat address, mem_read_write SHALL equal the registered write flag, and mem_data_in SHALL equal the registered wdata.
REQ-024 In IDLE and RESP, mem_chip_en and mem_read_write SHALL be 0, and mem_address and mem_data_in SHALL hold their last values.
REQ-025 A write SHALL spend exactly 1 cycle in ACCESS, then enter RESP with rsp_valid=1, rsp_rdata=0 and rsp_last=1, first visible in cycle T+2.
REQ-026 A read beat SHALL spend exactly READ_WAIT cycles in ACCESS, tracked by a wait counter.
REQ-027 On the edge ending the last ACCESS cycle, mem_data_out SHALL be captured into rsp_rdata and the FSM SHALL enter RESP.
REQ-028 The first read response SHALL be visible in cycle T+1+READ_WAIT.
REQ-029 In RESP, rsp_valid, rsp_rdata and rsp_last SHALL be held stable until rsp_ready=1.
REQ-030 No memory access SHALL occur while a response is stalled.
REQ-031 A read burst SHALL be req_len+1 beats, tracked by a down-counter; rsp_last SHALL be 1 only when that counter is 0.
REQ-032 On a RESP handshake with beats remaining, the address SHALL increment modulo 256 (0xFF wraps to 0x00), the counter SHALL decrement, and the FSM SHALL return to ACCESS.
REQ-033 On a RESP handshake for the last beat, the FSM SHALL return to IDLE, and rsp_valid SHALL be 0 the next cycle.
REQ-034 A new request SHALL be acceptable no earlier than the cycle after the last-beat handshake.
REQ-035 rsp_valid SHALL never be asserted outside RESP.
REQ-036 rsp_ready held high outside RESP SHALL have no effect.
REQ-037 A write with nonzero req_len SHALL be a single beat.

Reset
REQ-038 While rst_n=0, the FSM SHALL be in IDLE, and all outputs SHALL be 0 except req_ready=1; all counters SHALL be 0.
REQ-039 Reset asserted mid-burst SHALL immediately deassert mem_chip_en and rsp_valid and abandon the request with no further response.
REQ-040 After reset deasserts, the first accepted request SHALL behave as from a clean IDLE.

Verification
REQ-041 Write addr=0x10 data=0xA5, rsp_ready=1 -> 1 cycle with chip_en=1, read_write=1, address=0x10, data_in=0xA5; rsp_valid, rsp_last=1, rdata=0 at T+2.
REQ-042 READ_WAIT=2, read addr=0x10 len=0, memory model returns 0xA5 -> chip_en high 2 cycles, read_write=0; rsp_rdata=0xA5 and rsp_last=1 at T+3.
REQ-043 Read addr=0xFE len=3, memory model returns data=~addr -> beats at addresses FE, FF, 00, 01 with rdata 01, 00, FF, FE; rsp_last on beat 4 only.
REQ-044 rsp_ready held 0 for 5 cycles on beat 1 of a 2-beat read -> rsp outputs stable, chip_en=0 throughout the stall; beat 2 access starts the cycle after the handshake.
REQ-045 rst_n pulled low during ACCESS of beat 2 of a 4-beat read -> chip_en=0 and rsp_valid=0 immediately; req_ready=1; next request completes normally.
REQ-046 req_valid held high back-to-back with 2 writes -> second accepted only after the first response handshake; req_ready=0 while busy=1.
